ram_access_ctrl: RTL and testbench



---
 rtl/ram_access_pkg.sv | 28 ++
 rtl/ram_load_extend.sv | 28 ++
 rtl/ram_access_ctrl.sv | 152 +++++++++++++++
 tb/tb_ram_access_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_access_pkg.sv
// ram_access_pkg: shared types for the RAM load/store sequencer.
//   ADDR_W_DEF : default RAM byte-address width (1024 entries)
//   size_e     : access size (byte / half / word)
//   state_e    : sequencer states
//   norm_size  : maps the raw 2-bit size field to size_e (2'b11 -> word)
package ram_access_pkg;

  localparam int ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PH0  = 2'b01,
    ST_PH1  = 2'b10,
    ST_FIN  = 2'b11
  } state_e;

  // The unused encoding 2'b11 is a word access.
  function automatic size_e norm_size(input logic [1:0] raw);
    return (raw == 2'b11) ? SZ_WORD : size_e'(raw);
  endfunction

endpackage

// File: rtl/ram_load_extend.sv
// ram_load_extend: combinational little-endian load assembly.
// Ports:
//   b0..b3      in  8   bytes at addr+0 .. addr+3
//   size        in  2   size_e encoding (already normalised)
//   is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   rdata       out 32  extended load result
module ram_load_extend
  import ram_access_pkg::*;
(
  input  logic [7:0]  b0,
  input  logic [7:0]  b1,
  input  logic [7:0]  b2,
  input  logic [7:0]  b3,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] rdata
);

  always_comb begin
    rdata = {b3, b2, b1, b0};
    case (size)
      SZ_BYTE: rdata = {{24{~is_unsigned & b0[7]}}, b0};
      SZ_HALF: rdata = {{16{~is_unsigned & b1[7]}}, b1, b0};
      default: ;
    endcase
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: load/store sequencer driving both ports of a byte-wide
// dual-port data RAM. A request takes one (byte/half) or two (word) RAM
// phases followed by a FIN cycle that registers a one-cycle response.
//
// Build option: RAM_ACCESS_CTRL_MISALIGN_EN
//   defined   - any alignment is legal, bytes wrap modulo 2^ADDR_W, rsp_err=0
//   undefined - misaligned half/word is accepted but skips the RAM phases
//               and answers with rsp_err=1 one cycle earlier
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_we, req_size, req_unsigned, req_addr, req_wdata   request fields
//   rsp_valid, rsp_rdata, rsp_err                         one-cycle response
//   ram_addr_a/b, ram_din_a/b, ram_we_a/b                 RAM port drive
//   ram_dout_a/b               RAM read data, one cycle after address
module ram_access_ctrl
  import ram_access_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [7:0]        ram_din_a,
  output logic [7:0]        ram_din_b,
  output logic              ram_we_a,
  output logic              ram_we_b,
  input  logic [7:0]        ram_dout_a,
  input  logic [7:0]        ram_dout_b
);

  state_e              state_q, state_d;
  logic                we_q, uns_q, err_q;
  size_e               size_q, req_sz;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [15:0]         stage_q;     // bytes 0/1 of a word load, read in PH0
  logic                misaligned;
  logic [7:0]          fin_b0, fin_b1;
  logic [31:0]         ext_rdata;

  assign req_sz = norm_size(req_size);

`ifdef RAM_ACCESS_CTRL_MISALIGN_EN
  assign misaligned = 1'b0;
`else
  assign misaligned = ((req_sz == SZ_HALF) && req_addr[0]) ||
                      ((req_sz == SZ_WORD) && (req_addr[1:0] != 2'b00));
`endif

  // Next state and RAM port decode.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    state_d    = state_q;
    req_ready  = 1'b0;
    ram_addr_a = '0;
    ram_addr_b = '0;
    ram_din_a  = '0;
    ram_din_b  = '0;
    ram_we_a   = 1'b0;
    ram_we_b   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = misaligned ? ST_FIN : ST_PH0;
      end
      ST_PH0: begin
        ram_addr_a = addr_q;
        ram_addr_b = addr_q + ADDR_W'(1);
        ram_din_a  = wdata_q[7:0];
        ram_din_b  = wdata_q[15:8];
        ram_we_a   = we_q;
        ram_we_b   = we_q && (size_q != SZ_BYTE);
        state_d    = (size_q == SZ_WORD) ? ST_PH1 : ST_FIN;
      end
      ST_PH1: begin
        ram_addr_a = addr_q + ADDR_W'(2);
        ram_addr_b = addr_q + ADDR_W'(3);
        ram_din_a  = wdata_q[23:16];
        ram_din_b  = wdata_q[31:24];
        ram_we_a   = we_q;
        ram_we_b   = we_q;
        state_d    = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // In FIN the RAM outputs hold the last phase's reads: PH0 bytes for
  // byte/half, PH1 bytes (2/3) for a word, whose bytes 0/1 sit in staging.
  assign fin_b0 = (size_q == SZ_WORD) ? stage_q[7:0]  : ram_dout_a;
  assign fin_b1 = (size_q == SZ_WORD) ? stage_q[15:8] : ram_dout_b;

  ram_load_extend u_extend (
    .b0          (fin_b0),
    .b1          (fin_b1),
    .b2          (ram_dout_a),
    .b3          (ram_dout_b),
    .size        (size_q),
    .is_unsigned (uns_q),
    .rdata       (ext_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= SZ_BYTE;
      addr_q    <= '0;
      wdata_q   <= '0;
      stage_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      rsp_valid <= 1'b0;
      if (state_q == ST_IDLE && req_valid) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= misaligned;
        size_q  <= req_sz;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == ST_PH1) stage_q <= {ram_dout_b, ram_dout_a};
      if (state_q == ST_FIN) begin
        rsp_valid <= 1'b1;
        rsp_err   <= err_q;
        rsp_rdata <= (we_q || err_q) ? '0 : ext_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: bench for ram_access_ctrl with a behavioural RAM, a
// request-level reference model checked every cycle, directed cases with
// literal expectations, and a randomized request stream.
`timescale 1ns/1ps
module tb_ram_access_ctrl;

  localparam int ADDR_W = 10;
  localparam int MEM_N  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid, rsp_err;
  logic [31:0]       rsp_rdata;
  logic [ADDR_W-1:0] ram_addr_a, ram_addr_b;
  logic [7:0]        ram_din_a, ram_din_b, ram_dout_a, ram_dout_b;
  logic              ram_we_a, ram_we_b;

  ram_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_din_a(ram_din_a), .ram_din_b(ram_din_b),
    .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
    .ram_dout_a(ram_dout_a), .ram_dout_b(ram_dout_b)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;   // number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  // Behavioural dual-port RAM, read-first, one-cycle read latency.
  logic [7:0] ram [MEM_N];
  bit ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < MEM_N; i++) ram[i] <= pat(i);
      ram_init <= 1'b1;
    end else begin
      if (ram_we_a) ram[ram_addr_a] <= ram_din_a;
      if (ram_we_b) ram[ram_addr_b] <= ram_din_b;
    end
    ram_dout_a <= ram[ram_addr_a];
    ram_dout_b <= ram[ram_addr_b];
  end

  // Reference model: each accepted request becomes one expected response
  // with its due cycle; stores are applied to ref_mem when they complete.
  typedef struct {
    int                due;
    logic              err;
    logic              we;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
  } exp_t;

  exp_t       exp_q[$];
  int         rsp_log[$];
  logic [7:0] ref_mem [MEM_N];
  bit         ref_init = 1'b0;

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  always @(negedge clk) begin : model_p
    exp_t        e;
    bit          exp_v;
    int          lat;
    int          nb;
    logic [31:0] v;
    if (!ref_init) begin
      for (int i = 0; i < MEM_N; i++) ref_mem[i] = pat(i);
      ref_init = 1'b1;
    end
    if (!rst_n) begin
      exp_q.delete();
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_ram_we", {ram_we_b, ram_we_a}, 2'b00);
    end else begin
      if (rsp_valid) rsp_log.push_back(cyc);
      exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      check("rsp_valid", rsp_valid, exp_v);
      if (exp_v) begin
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", rsp_err, e.err);
        if (e.we && !e.err)
          for (int k = 0; k < nbytes(e.size); k++)
            ref_mem[(int'(e.addr) + k) % MEM_N] = e.wdata[8*k +: 8];
      end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        void'(exp_q.pop_front());
      end
      check("req_ready", req_ready, exp_q.size() == 0);
      if (exp_q.size() == 0 || !exp_q[0].we || exp_q[0].err)
        check("ram_we_quiet", {ram_we_b, ram_we_a}, 2'b00);
      if (req_valid && req_ready) begin
        e.we    = req_we;
        e.size  = (req_size == 2'b11) ? 2'b10 : req_size;
        e.addr  = req_addr;
        e.wdata = req_wdata;
`ifdef RAM_ACCESS_CTRL_MISALIGN_EN
        e.err = 1'b0;
`else
        e.err = (e.size == 2'd1 && e.addr[0]) || (e.size == 2'd2 && e.addr[1:0] != 2'b00);
`endif
        nb = nbytes(e.size);
        v  = 32'h0;
        for (int k = 0; k < nb; k++) v[8*k +: 8] = ref_mem[(int'(e.addr) + k) % MEM_N];
        if (!req_unsigned && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
        e.rdata = (e.we || e.err) ? 32'h0 : v;
        lat     = e.err ? 2 : (nb == 4 ? 4 : 3);
        // Accept happens at the next edge (cyc+1); response cycle E+lat is
        // observed at the negedge where cyc == E+lat-1.
        e.due   = cyc + lat;
        exp_q.push_back(e);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [ADDR_W-1:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
  endtask

  task automatic scramble();
    req_valid    = 1'b0;
    req_we       = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = ADDR_W'($urandom);
    req_wdata    = $urandom;
  endtask

  // Waits for acceptance; returns E = edge index of the accepting edge.
  task automatic wait_accept(output int e_edge);
    int t;
    t = 0;
    e_edge = -1;
    while (1) begin
      @(negedge clk);
      if (req_ready) break;
      t++;
      if (t > 20) begin
        n_tests++; n_fail++;
        $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles", t);
        return;
      end
    end
    @(posedge clk); #1;
    e_edge = cyc;
  endtask

  // Waits for rsp_valid; returns its cycle number in the E+n convention.
  task automatic wait_rsp(output int rc, output logic [31:0] rd, output logic er);
    rc = -1; rd = 'x; er = 'x;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (rsp_valid) begin
        rc = cyc + 1; rd = rsp_rdata; er = rsp_err;
        return;
      end
    end
    n_tests++; n_fail++;
    $display("FAIL rsp_timeout: no rsp_valid within 12 cycles");
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er);
    int e_edge, rc;
    drive(we, sz, uns, a, wd);
    wait_accept(e_edge);
    scramble();
    wait_rsp(rc, rd, er);
    lat = rc - e_edge;
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random tests ----------------
  initial begin : main_p
    int          lat, e1, e2, rc, nlog, nmis;
    logic [31:0] rd;
    logic        er;
    logic [ADDR_W-1:0] a;

    scramble();
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", req_ready, 1'b1);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err", rsp_err, 1'b0);
    check("reset_ram_we", {ram_we_b, ram_we_a}, 2'b00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word store then word load.
    do_req(1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, lat, rd, er);
    check("st_word_lat", lat, 4);
    check("st_word_rdata", rd, 32'h0);
    check("st_word_err", er, 1'b0);
    check("st_word_mem", {ram[10'h013], ram[10'h012], ram[10'h011], ram[10'h010]}, 32'hDEADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, lat, rd, er);
    check("ld_word_lat", lat, 4);
    check("ld_word_rdata", rd, 32'hDEADBEEF);
    check("ld_word_err", er, 1'b0);
    do_req(1'b0, 2'b11, 1'b0, 10'h010, 32'h0, lat, rd, er);
    check("ld_size3_lat", lat, 4);
    check("ld_size3_rdata", rd, 32'hDEADBEEF);

    // Byte/half extension.
    do_req(1'b1, 2'b00, 1'b0, 10'h020, 32'h0000_0080, lat, rd, er);
    check("st_byte_lat", lat, 3);
    do_req(1'b1, 2'b00, 1'b0, 10'h021, 32'h0000_007F, lat, rd, er);
    do_req(1'b0, 2'b00, 1'b0, 10'h020, 32'h0, lat, rd, er);
    check("ld_byte_s_lat", lat, 3);
    check("ld_byte_s", rd, 32'hFFFFFF80);
    do_req(1'b0, 2'b00, 1'b1, 10'h020, 32'h0, lat, rd, er);
    check("ld_byte_u", rd, 32'h00000080);
    do_req(1'b0, 2'b01, 1'b0, 10'h020, 32'h0, lat, rd, er);
    check("ld_half_s", rd, 32'h00007F80);

    // Half store across the top of the address space.
    do_req(1'b1, 2'b01, 1'b0, 10'h3FF, 32'h0000_1234, lat, rd, er);
`ifdef RAM_ACCESS_CTRL_MISALIGN_EN
    check("wrap_st_lat", lat, 3);
    check("wrap_st_err", er, 1'b0);
    check("wrap_mem", {ram[10'h000], ram[10'h3FF]}, 16'h1234);
    do_req(1'b0, 2'b01, 1'b0, 10'h3FF, 32'h0, lat, rd, er);
    check("wrap_ld", rd, 32'h00001234);
    do_req(1'b0, 2'b10, 1'b0, 10'h011, 32'h0, lat, rd, er);
    check("misal_word_ld", rd, {pat(20), 24'hDEADBE});
`else
    check("misal_st_lat", lat, 2);
    check("misal_st_err", er, 1'b1);
    check("misal_st_rdata", rd, 32'h0);
    check("misal_mem", {ram[10'h000], ram[10'h3FF]}, {pat(0), pat(10'h3FF)});
    do_req(1'b0, 2'b10, 1'b0, 10'h011, 32'h0, lat, rd, er);
    check("misal_word_lat", lat, 2);
    check("misal_word_err", er, 1'b1);
    check("misal_word_rdata", rd, 32'h0);
`endif

    // Back-to-back: byte load then word load with req_valid held.
    nlog = rsp_log.size();
    drive(1'b0, 2'b00, 1'b1, 10'h020, 32'h0);
    wait_accept(e1);
    drive(1'b0, 2'b10, 1'b0, 10'h010, 32'h0);
    wait_accept(e2);
    scramble();
    check("b2b_accept_gap", e2 - e1, 3);
    wait_rsp(rc, rd, er);
    check("b2b_second_rsp_cycle", rc - e2, 4);
    check("b2b_second_rdata", rd, 32'hDEADBEEF);
    @(negedge clk);
    check("b2b_rsp_one_cycle", rsp_valid, 1'b0);
    check("b2b_rsp_count", rsp_log.size() - nlog, 2);
    if (rsp_log.size() - nlog == 2)
      check("b2b_first_rsp_cycle", rsp_log[nlog] + 1 - e1, 3);
    @(posedge clk); #1;

    // Reset during PH1 of a word store. Bytes 0/1 carry the existing
    // contents so the image is the same whether or not they were written.
    drive(1'b1, 2'b10, 1'b0, 10'h100, {8'hA5, 8'h5A, pat(10'h101), pat(10'h100)});
    wait_accept(e1);
    scramble();
    @(posedge clk); #2;
    check("abort_we_in_ph1", {ram_we_b, ram_we_a}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("abort_we_async", {ram_we_b, ram_we_a}, 2'b00);
    check("abort_ready", req_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    do_req(1'b0, 2'b10, 1'b0, 10'h100, 32'h0, lat, rd, er);
    check("post_reset_lat", lat, 4);
    check("post_reset_rdata", rd, {pat(10'h103), pat(10'h102), pat(10'h101), pat(10'h100)});

    // Randomized stream with gaps and back-to-back requests.
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 7) == 0) ? ADDR_W'(10'h3F8 + $urandom_range(0, 7))
                                      : ADDR_W'($urandom_range(0, 63));
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), a, $urandom);
      wait_accept(e1);
      scramble();
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    repeat (8) @(posedge clk);
    #1;
    check("pending_responses", exp_q.size(), 0);
    nmis = 0;
    for (int i = 0; i < MEM_N; i++) if (ram[i] !== ref_mem[i]) nmis++;
    check("mem_image_mismatches", nmis, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
